// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, write-word layout and segment decode for the scan scheduler
package seg_pkg;

    typedef logic [5:0] seg_wdata_t;

    localparam logic [7:0] SEG_OFF  = 8'h80;
    localparam logic [5:0] EN_OFF   = 6'b111111;
    localparam int         WD_BLANK = 5;
    localparam int         WD_DP    = 4;
    localparam seg_wdata_t WD_RESET = 6'b100000;

    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // A blanked digit keeps DP off as well, so it looks identical to the dark slot
    function automatic logic [7:0] seg_byte(input seg_wdata_t wd);
        if (wd[WD_BLANK]) begin
            return SEG_OFF;
        end
        return {~wd[WD_DP], hex2seg(wd[3:0])};
    endfunction

endpackage

// File: rtl/seg_rr_arbiter.sv
// rtl/seg_rr_arbiter.sv - two-way round-robin write arbiter; req[0]/gnt[0] = A, req[1]/gnt[1] = B
module seg_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;

    // The pointer only moves on contention; an uncontested grant leaves priority alone
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt   = ptr_q ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// rtl/seg_scan_scheduler.sv - six-digit seven-segment scan controller with a shared, arbitrated digit buffer
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50_000,
    parameter int BLANK_CYC = 500,
    parameter int DIGITS    = 6,
    parameter int CNT_W     = 16
) (
    input  logic       CLK_50M,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       A_REQ,
    input  logic [2:0] A_IDX,
    input  logic [5:0] A_WDATA,
    output logic       A_ACK,
    input  logic       B_REQ,
    input  logic [2:0] B_IDX,
    input  logic [5:0] B_WDATA,
    output logic       B_ACK,
    output logic [5:0] SEG_EN,
    output logic [7:0] SEG_DATA
);

    localparam logic ST_BLANK = 1'b0;
    localparam logic ST_SHOW  = 1'b1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    seg_wdata_t       digit_buf_q [DIGITS];
    seg_wdata_t       digit_buf_d [DIGITS];
    seg_wdata_t       disp_q, disp_d;
    seg_wdata_t       cur_wd;
    logic [5:0]       seg_en_q, seg_en_d;
    logic [7:0]       seg_data_q, seg_data_d;
    logic             a_ack_q, a_ack_d;
    logic             b_ack_q, b_ack_d;
    logic [1:0]       req;
    logic [1:0]       gnt;

    // A request seen in its own ACK cycle is the one just served, not a new one
    assign req = {B_REQ & ~b_ack_q, A_REQ & ~a_ack_q};

    seg_rr_arbiter u_arb (
        .clk (CLK_50M),
        .rst (RST),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        cur_wd = WD_RESET;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_wd = digit_buf_q[i];
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        idx_d   = idx_q;
        disp_d  = disp_q;
        if (!ENABLE) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            idx_d   = '0;
        end else begin
            cnt_d = (cnt_q == SLOT_LAST) ? '0 : cnt_q + CNT_W'(1);
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        disp_d  = cur_wd;
                    end
                end
                default: begin
                    if (cnt_q == SLOT_LAST) begin
                        state_d = ST_BLANK;
                        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
                    end
                end
            endcase
        end
    end

    // Outputs are built from next-state values so the pins change on the same edge as the FSM
    always_comb begin
        seg_en_d   = EN_OFF;
        seg_data_d = SEG_OFF;
        if (state_d == ST_SHOW) begin
            seg_en_d   = ~(6'b000001 << idx_d);
            seg_data_d = seg_byte(disp_d);
        end
    end

    always_comb begin
        a_ack_d = gnt[0];
        b_ack_d = gnt[1];
        for (int i = 0; i < DIGITS; i++) begin
            digit_buf_d[i] = digit_buf_q[i];
            if (gnt[0] && A_IDX == 3'(i)) begin
                digit_buf_d[i] = A_WDATA;
            end
            if (gnt[1] && B_IDX == 3'(i)) begin
                digit_buf_d[i] = B_WDATA;
            end
        end
    end

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            cnt_q      <= '0;
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            disp_q     <= WD_RESET;
            seg_en_q   <= EN_OFF;
            seg_data_q <= SEG_OFF;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_q[i] <= WD_RESET;
            end
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            seg_en_q   <= seg_en_d;
            seg_data_q <= seg_data_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf_q[i] <= digit_buf_d[i];
            end
        end
    end

    assign SEG_EN   = seg_en_q;
    assign SEG_DATA = seg_data_q;
    assign A_ACK    = a_ack_q;
    assign B_ACK    = b_ack_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// tb/tb_seg_scan_scheduler.sv - directed self-checking bench for seg_scan_scheduler (SCAN_DIV=8, BLANK_CYC=2)
module tb_seg_scan_scheduler;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int ND = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       a_req, b_req;
    logic [2:0] a_idx, b_idx;
    logic [5:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [5:0] seg_en;
    logic [7:0] seg_data;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         t        = 0;
    logic [7:0] exp_disp = 8'h80;
    logic [5:0] exp_buf [ND];

    always #5 clk = ~clk;

    seg_scan_scheduler #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .DIGITS    (ND),
        .CNT_W     (4)
    ) dut (
        .CLK_50M  (clk),
        .RST      (rst),
        .ENABLE   (enable),
        .A_REQ    (a_req),
        .A_IDX    (a_idx),
        .A_WDATA  (a_wdata),
        .A_ACK    (a_ack),
        .B_REQ    (b_req),
        .B_IDX    (b_idx),
        .B_WDATA  (b_wdata),
        .B_ACK    (b_ack),
        .SEG_EN   (seg_en),
        .SEG_DATA (seg_data)
    );

    function automatic logic [7:0] seg_of(input logic [5:0] wd);
        logic [6:0] s;
        case (wd[3:0])
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return wd[5] ? 8'h80 : {~wd[4], s};
    endfunction

    // Reference slot timeline: t = enabled clocks since reset or ENABLE low
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t        <= 0;
            exp_disp <= 8'h80;
        end else if (!enable) begin
            t <= 0;
        end else begin
            if (((t + 1) % SD) == BC) begin
                exp_disp <= seg_of(exp_buf[((t + 1) / SD) % ND]);
            end
            t <= t + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sweep(input int n);
        logic [5:0] e_en;
        logic [7:0] e_data;
        for (int k = 0; k < n; k++) begin
            tick();
            if ((t % SD) >= BC) begin
                e_en   = ~(6'b000001 << ((t / SD) % ND));
                e_data = exp_disp;
            end else begin
                e_en   = 6'h3F;
                e_data = 8'h80;
            end
            check($sformatf("scan_en t=%0d", t), seg_en, e_en);
            check($sformatf("scan_data t=%0d", t), seg_data, e_data);
        end
    endtask

    task automatic wait_en(input logic [5:0] target, input string tag);
        int n;
        n = 0;
        while (seg_en !== target && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, seg_en, target);
    endtask

    task automatic do_write(input bit side_b, input logic [2:0] idx, input logic [5:0] wd,
                            input string tag);
        int   lat;
        logic got;
        if (side_b) begin
            b_idx = idx; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_idx = idx; a_wdata = wd; a_req = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 4) begin
            tick();
            lat++;
            got = side_b ? b_ack : a_ack;
        end
        if (got && idx < ND) begin
            exp_buf[idx] = wd;
        end
        check({tag, "_ack_latency"}, lat, 1);
        if (side_b) b_req = 1'b0;
        else        a_req = 1'b0;
        tick();
        check({tag, "_ack_pulse"}, side_b ? b_ack : a_ack, 1'b0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        a_idx = '0; b_idx = '0; a_wdata = '0; b_wdata = '0;
        for (int i = 0; i < ND; i++) exp_buf[i] = 6'b100000;

        tick(); tick();
        check("reset_en", seg_en, 6'h3F);
        check("reset_data", seg_data, 8'h80);
        check("reset_a_ack", a_ack, 1'b0);
        check("reset_b_ack", b_ack, 1'b0);

        rst = 1'b0; enable = 1'b1;
        tick();
        check("release_blank_en", seg_en, 6'h3F);
        tick();
        check("release_show_en", seg_en, 6'h3E);
        check("release_show_data", seg_data, 8'h80);
        sweep(50);

        do_write(1'b0, 3'd2, 6'b010101, "a_idx2");
        sweep(2);
        wait_en(6'h3B, "slot2");
        check("slot2_data", seg_data, 8'h6D);
        sweep(48);

        a_idx = 3'd1; a_wdata = 6'b000011;
        b_idx = 3'd3; b_wdata = 6'b011010;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_ack%0d", k), {a_ack, b_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 0) exp_buf[1] = 6'b000011;
            else            exp_buf[3] = 6'b011010;
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
        check("rr_idle", {a_ack, b_ack}, 2'b00);
        sweep(2);
        wait_en(6'h3D, "slot1");
        check("slot1_data", seg_data, 8'hCF);
        wait_en(6'h37, "slot3");
        check("slot3_data", seg_data, 8'h77);
        sweep(48);

        wait_en(6'h3E, "slot0_a");
        tick();
        do_write(1'b1, 3'd0, 6'b000001, "b_idx0");
        check("same_slot_en", seg_en, 6'h3E);
        check("same_slot_data", seg_data, 8'h80);
        tick(); tick(); tick(); tick();
        wait_en(6'h3E, "slot0_b");
        check("next_slot0_data", seg_data, 8'h86);
        sweep(48);

        do_write(1'b0, 3'd7, 6'b000000, "a_idx7");
        sweep(50);

        wait_en(6'h37, "slot3_dis");
        enable = 1'b0;
        tick();
        check("disable_en", seg_en, 6'h3F);
        check("disable_data", seg_data, 8'h80);
        tick();
        check("disable_hold_en", seg_en, 6'h3F);
        enable = 1'b1;
        sweep(20);

        check("pre_rst_show", seg_en, 6'h3B);
        rst = 1'b1;
        for (int i = 0; i < ND; i++) exp_buf[i] = 6'b100000;
        #1;
        check("rst_async_en", seg_en, 6'h3F);
        check("rst_async_data", seg_data, 8'h80);
        check("rst_async_ack", {a_ack, b_ack}, 2'b00);
        tick();
        rst = 1'b0;
        sweep(52);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
